// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared AES key-schedule definitions: FSM encodings, word-generator select codes,
// S-box table and the GF(2^8) helpers used by the expansion datapath.
package aes_key_schedule_ctrl_pkg;

    // Controller state encodings
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StExpand = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // Word generator transform select
    typedef logic [1:0] word_sel_t;
    localparam word_sel_t SelPlain = 2'd0;  // t = w[i-1]
    localparam word_sel_t SelRot   = 2'd1;  // t = SubWord(RotWord(w[i-1])) ^ rcon
    localparam word_sel_t SelSub   = 2'd2;  // t = SubWord(w[i-1])

    // Forward S-box, entry 0 in the MSBs
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x sits at bit offset (255-x)*8, and 255-x == ~x
        return SboxTable[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_word_gen.sv
// Combinational generator for one expanded key word: w_new = w[i-Nk] ^ t(w[i-1]).
module aes_key_schedule_ctrl_word_gen
    import aes_key_schedule_ctrl_pkg::*;
(
    input  logic [31:0] i_w_prev,
    input  logic [31:0] i_w_back,
    input  logic [7:0]  i_rcon,
    input  word_sel_t   i_sel,
    output logic [31:0] o_w_new
);

    logic [31:0] w_rot;
    logic [31:0] w_t;

    // Select the temp-word transform and fold in w[i-Nk]
    always_comb begin
        w_rot = {i_w_prev[23:0], i_w_prev[31:24]};
        w_t   = i_w_prev;
        case (i_sel)
            SelRot:  w_t = sub_word(w_rot) ^ {i_rcon, 24'h000000};
            SelSub:  w_t = sub_word(i_w_prev);
            default: w_t = i_w_prev;
        endcase
        o_w_new = i_w_back ^ w_t;
    end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES key-schedule controller: expands an Nk-word key one word per clock into a
// round-key file and serves 128-bit round keys by index.
module aes_key_schedule_ctrl
    import aes_key_schedule_ctrl_pkg::*;
#(
    parameter int unsigned Nk = 6,
    parameter int unsigned Nr = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Nk*32-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk_out
);

    localparam int unsigned NumWords = 4 * (Nr + 1);
    localparam int unsigned IdxW     = $clog2(NumWords + 1);

    logic [1:0]      r_state;
    logic [IdxW-1:0] r_i;
    logic [2:0]      r_phase;  // i % Nk, tracked incrementally
    logic [7:0]      r_rcon;
    logic            r_busy;
    logic            r_done;
    logic            r_keys_valid;
    logic [31:0]     r_w [NumWords];

    logic [31:0]     w_w_prev;
    logic [31:0]     w_w_back;
    logic [31:0]     w_w_new;
    word_sel_t       w_sel;
    logic [IdxW-1:0] w_base;

    assign w_w_prev = r_w[r_i - IdxW'(1)];
    assign w_w_back = r_w[r_i - IdxW'(Nk)];

    // Pick the transform for word i from its position within the Nk-word period
    always_comb begin
        w_sel = SelPlain;
        if (r_phase == 3'd0) begin
            w_sel = SelRot;
        end else if (Nk == 8 && r_phase == 3'd4) begin
            w_sel = SelSub;
        end
    end

    aes_key_schedule_ctrl_word_gen u_word_gen (
        .i_w_prev (w_w_prev),
        .i_w_back (w_w_back),
        .i_rcon   (r_rcon),
        .i_sel    (w_sel),
        .o_w_new  (w_w_new)
    );

    // Sequencer: key capture, word-per-cycle expansion, completion handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_i          <= '0;
            r_phase      <= '0;
            r_rcon       <= 8'h01;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int k = 0; k < NumWords; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        for (int k = 0; k < Nk; k++) begin
                            r_w[k] <= key[(Nk - k) * 32 - 1 -: 32];
                        end
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= StLoad;
                    end
                end
                StLoad: begin
                    r_i     <= IdxW'(Nk);
                    r_phase <= '0;
                    r_rcon  <= 8'h01;
                    r_state <= StExpand;
                end
                StExpand: begin
                    r_w[r_i] <= w_w_new;
                    r_i      <= r_i + IdxW'(1);
                    r_phase  <= (r_phase == 3'(Nk - 1)) ? 3'd0 : r_phase + 3'd1;
                    if (w_sel == SelRot) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (r_i == IdxW'(NumWords - 1)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Round-key read port; indices past Nr return zero
    always_comb begin
        w_base = IdxW'({rk_idx, 2'b00});
        rk_out = '0;
        if (rk_idx <= 4'(Nr)) begin
            rk_out = {r_w[w_base], r_w[w_base + IdxW'(1)],
                      r_w[w_base + IdxW'(2)], r_w[w_base + IdxW'(3)]};
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Bench for aes_key_schedule_ctrl: AES-128/192/256 instances checked against a
// FIPS-197 style reference model with a GF(2^8)-derived S-box.
module tb_aes_key_schedule_ctrl;

    logic clk;
    logic rst_n;

    logic         st4, st6, st8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [3:0]   idx4, idx6, idx8;
    logic         busy4, busy6, busy8;
    logic         done4, done6, done8;
    logic         kv4, kv6, kv8;
    logic [127:0] rk4, rk6, rk8;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sref [256];
    logic [31:0] mw [60];
    logic [7:0]  rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_key_schedule_ctrl #(.Nk(4), .Nr(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .key(key4), .busy(busy4), .done(done4),
        .keys_valid(kv4), .rk_idx(idx4), .rk_out(rk4)
    );
    aes_key_schedule_ctrl #(.Nk(6), .Nr(12)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(st6), .key(key6), .busy(busy6), .done(done6),
        .keys_valid(kv6), .rk_idx(idx6), .rk_out(rk6)
    );
    aes_key_schedule_ctrl #(.Nk(8), .Nr(14)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .key(key8), .busy(busy8), .done(done8),
        .keys_valid(kv8), .rk_idx(idx8), .rk_out(rk8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                      ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] ref_sub(input logic [31:0] x);
        return {sref[x[31:24]], sref[x[23:16]], sref[x[15:8]], sref[x[7:0]]};
    endfunction

    task automatic ref_expand(input logic [255:0] k, input int nk);
        int          total;
        logic [31:0] t;
        total = 4 * (nk + 7);
        for (int j = 0; j < nk; j++) mw[j] = k[255 - 32 * j -: 32];
        for (int i = nk; i < total; i++) begin
            t = mw[i - 1];
            if (i % nk == 0) begin
                t = ref_sub({t[23:0], t[31:24]}) ^ {rc_tab[i / nk - 1], 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = ref_sub(t);
            end
            mw[i] = mw[i - nk] ^ t;
        end
    endtask

    // ---------------- DUT access helpers ----------------
    task automatic drive(input int s, input logic st, input logic [255:0] k);
        case (s)
            0:       begin st4 = st; key4 = k[255 -: 128]; end
            1:       begin st6 = st; key6 = k[255 -: 192]; end
            default: begin st8 = st; key8 = k; end
        endcase
    endtask

    task automatic set_idx(input int s, input int v);
        case (s)
            0:       idx4 = 4'(v);
            1:       idx6 = 4'(v);
            default: idx8 = 4'(v);
        endcase
    endtask

    function automatic logic [2:0] flags(input int s);
        case (s)
            0:       return {busy4, done4, kv4};
            1:       return {busy6, done6, kv6};
            default: return {busy8, done8, kv8};
        endcase
    endfunction

    function automatic logic [127:0] rk_of(input int s);
        case (s)
            0:       return rk4;
            1:       return rk6;
            default: return rk8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input int s, input logic [2:0] exp);
        check($sformatf("%s_s%0d_busy_done_kv", tag, s), {125'd0, flags(s)}, {125'd0, exp});
    endtask

    // Compare every round key against the model, plus out-of-range indices
    task automatic check_schedule(input int s, input logic [255:0] k);
        int nk = 4 + 2 * s;
        int nr = nk + 6;
        ref_expand(k, nk);
        for (int r = 0; r <= nr; r++) begin
            set_idx(s, r);
            #1;
            check($sformatf("s%0d_rk%0d", s, r), rk_of(s),
                  {mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]});
        end
        if (nr + 1 < 15) begin
            set_idx(s, nr + 1);
            #1;
            check($sformatf("s%0d_rk_past_nr", s), rk_of(s), 128'h0);
        end
        set_idx(s, 15);
        #1;
        check($sformatf("s%0d_rk15", s), rk_of(s), 128'h0);
    endtask

    // Full expansion; optionally pulse start with another key at cycle glitch_at
    task automatic expand_and_check(input int s, input logic [255:0] k, input int glitch_at,
                                    input logic [255:0] gk);
        int         nk = 4 + 2 * s;
        int         w  = 4 * (nk + 7) - nk;
        int         done_cnt = 0;
        int         first = 0;
        logic [2:0] f;
        drive(s, 1'b1, k);
        @(posedge clk); #1;
        drive(s, 1'b0, k);
        check_flags("load", s, 3'b100);
        for (int n = 1; n <= w + 6; n++) begin
            @(posedge clk); #1;
            drive(s, n == glitch_at, (glitch_at > 0 && n >= glitch_at) ? gk : k);
            f = flags(s);
            if (f[1]) begin
                done_cnt++;
                if (first == 0) first = n;
            end
            if (n == 1) check_flags("expand", s, 3'b100);
            if (n == w + 2) check_flags("done", s, 3'b011);
        end
        check($sformatf("s%0d_done_count", s), 128'(done_cnt), 128'd1);
        check($sformatf("s%0d_latency", s), 128'(first), 128'(w + 2));
        check_schedule(s, k);
    endtask

    task automatic kat(input int s, input int idx, input logic [127:0] exp);
        set_idx(s, idx);
        #1;
        check($sformatf("kat_s%0d_rk%0d", s, idx), rk_of(s), exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] ka, kb;
        logic [2:0]   f;
        int           n;

        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        set_idx(0, 0);
        set_idx(1, 0);
        set_idx(2, 0);
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check_flags("reset", s, 3'b000);
            check($sformatf("reset_s%0d_rk0", s), rk_of(s), 128'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer schedules
        expand_and_check(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, '0);
        kat(0, 1, 128'ha0fafe1788542cb123a339392a6c7605);
        kat(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand_and_check(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                         0, '0);
        kat(1, 12, 128'he98ba06f448c773c8ecc720401002202);
        expand_and_check(2,
            256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0, '0);
        kat(2, 14, 128'hfe4890d1e6188d0b046df344706c631e);

        // Random keys on every key size
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                ka = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
                expand_and_check(s, ka, 0, '0);
            end
        end

        // start with a different key during expansion must be ignored
        ka = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        kb = ~ka;
        expand_and_check(1, ka, 5, kb);

        // Reset at EXPAND cycle 10 aborts, then a clean expansion follows
        ka = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        drive(2, 1'b1, ka);
        @(posedge clk); #1;
        drive(2, 1'b0, ka);
        repeat (10) @(posedge clk);
        #1;
        check_flags("pre_abort", 2, 3'b100);
        rst_n = 1'b0;
        #1;
        check_flags("abort", 2, 3'b000);
        set_idx(2, 0);
        #1;
        check("abort_s2_rk0_cleared", rk_of(2), 128'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expand_and_check(2, ka, 0, '0);

        // Back-to-back: restart the cycle done is high
        ka = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        kb = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        set_idx(0, 15);
        drive(0, 1'b1, ka);
        @(posedge clk); #1;
        drive(0, 1'b0, ka);
        n = 0;
        f = flags(0);
        while (!f[1] && n < 60) begin
            @(posedge clk); #1;
            n++;
            f = flags(0);
            check($sformatf("b2b_first_rk15_cyc%0d", n), rk_of(0), 128'h0);
        end
        check("b2b_first_latency", 128'(n), 128'd42);
        check_flags("b2b_done", 0, 3'b011);
        drive(0, 1'b1, kb);
        @(posedge clk); #1;
        drive(0, 1'b0, kb);
        check_flags("b2b_load", 0, 3'b100);
        check("b2b_load_rk15", rk_of(0), 128'h0);
        n = 0;
        f = flags(0);
        while (!f[1] && n < 60) begin
            @(posedge clk); #1;
            n++;
            f = flags(0);
            check($sformatf("b2b_second_rk15_cyc%0d", n), rk_of(0), 128'h0);
        end
        check("b2b_second_latency", 128'(n), 128'd42);
        check_schedule(0, kb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
